mul_unit: RTL and testbench
===========================

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 Clk  input  1  single clock; all state changes on rising edge.
REQ-002 nReset  input  1  reset, asynchronous and active-low.
REQ-003 ALUOp  input  1  decoder ALU-class strobe; qualifies Func for MULT/MULTU/MFHI/MFLO/MTHI/MTLO.
REQ-004 MULOp  input  1  decoder SPECIAL2-class strobe; qualifies Func for MADD/MADDU/MSUB/MSUBU/MUL.
REQ-005 Func  input  6  function code from the decoder.
REQ-006 A  input  32  rs operand.
REQ-007 B  input  32  rt operand.
REQ-008 Busy  output  1  high while a multiply is in progress.
REQ-009 Stall  output  1  combinational; high when a valid command is presented while Busy.
REQ-010 Result  output  32  MFHI/MFLO/MUL data.
REQ-011 ResultValid  output  1  qualifies Result for one cycle.
REQ-012 HI, LO  output  32 each  architectural HI/LO registers.

Function
REQ-013 Command decodes, with ALUOp=1 and MULOp=0: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19.
REQ-014 Command decodes, with MULOp=1 and ALUOp=0: MADD 0x00, MADDU 0x01, MUL 0x02, MSUB 0x04, MSUBU 0x05.
REQ-015 Any other Func, ALUOp=MULOp=1, or both low SHALL be no command: no state change, Stall=0, ResultValid=0.
REQ-016 FSM states IDLE, MULT, FIN; IDLE->MULT on accepting a multiply-class command; MULT->FIN after 32 iteration cycles; FIN->IDLE unconditionally.
REQ-017 A command is accepted only in IDLE; in MULT or FIN a valid command SHALL be ignored with Stall=1.
REQ-018 Busy SHALL equal (state != IDLE).
REQ-019 On accept, the unit latches operand magnitudes (signed ops: two's-complement absolute value), the result sign (A[31]^B[31] for signed, 0 for unsigned) and the opcode.
REQ-020 MULT performs one shift-add step per cycle, producing the unsigned 64-bit product of the 32-bit magnitudes after exactly 32 cycles.
REQ-021 FIN applies the sign (64-bit negate), then: MULT/MULTU {HI,LO}=P; MADD/MADDU {HI,LO}+=P; MSUB/MSUBU {HI,LO}-=P; all modulo 2^64.
REQ-022 MUL in FIN SHALL drive Result=P[31:0] with ResultValid=1 and leave HI/LO unchanged.
REQ-023 Multiply latency: HI/LO updated at the 34th rising edge after the accepting edge (accept, 32 MULT, 1 FIN); Busy high for exactly 33 cycles.
REQ-024 MFHI/MFLO in IDLE SHALL drive Result=HI/LO with ResultValid=1 combinationally in the same cycle.
REQ-025 MTHI/MTLO in IDLE SHALL load HI/LO from A at that edge; single cycle; Busy stays 0.
REQ-026 Outside the REQ-022/REQ-024 cases Result=0 and ResultValid=0.
REQ-027 Signed magnitude of 0x80000000 is 0x80000000 treated as unsigned 2^31 (no overflow).

Reset
REQ-028 nReset low SHALL immediately force state=IDLE, HI=0, LO=0, Busy=0, ResultValid=0, Result=0 and clear internal product/operand registers, including mid-operation.
REQ-029 The first command is accepted on the first rising edge with nReset high.

Configuration
REQ-030 Macro MUL_ACC_EN defined: MADD/MADDU/MSUB/MSUBU behave per REQ-021.
REQ-031 MUL_ACC_EN undefined: those four Func codes SHALL decode as no command (REQ-015), and no 64-bit accumulate adder is built; MUL/MULT/MULTU unaffected.

Verification
REQ-032 Reset, MULT A=0xFFFFFFFF B=0x00000002 -> after 34 edges HI=0xFFFFFFFF LO=0xFFFFFFFE; Busy high 33 cycles.
REQ-033 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001.
REQ-034 MTHI A=0, MTLO A=10, MADD A=3 B=4, then MSUB A=1 B=0x80000000 (with MUL_ACC_EN) -> after MADD LO=22 HI=0; after MSUB HI=0x00000000 LO=0x80000016.
REQ-035 MUL A=7 B=-6 -> ResultValid one cycle in FIN with Result=0xFFFFFFD6; HI/LO unchanged; MFLO presented during Busy -> Stall=1, ignored; re-presented in IDLE -> Result=LO same cycle.
REQ-036 nReset low at MULT cycle 10 -> HI=LO=0, Busy=0 immediately; next MULT 5x5 gives LO=25.
REQ-037 MUL_ACC_EN undefined, MADD A=3 B=4 -> Busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mul_unit.sv
// mul_unit: iterative 32x32 shift-add multiplier with HI/LO registers and MFHI/MFLO/MTHI/MTLO/MUL support.
// Define MUL_ACC_EN to enable MADD/MADDU/MSUB/MSUBU and the 64-bit accumulate adder.
module mul_unit (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        ALUOp,
  input  logic        MULOp,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] Result,
  output logic        ResultValid,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {IDLE, MULT, FIN} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MUL, OP_MADD, OP_MSUB} op_t;
  state_t state, state_nxt;
  op_t op, op_nxt;
  logic alu, mulc, is_mfhi, is_mthi, is_mflo, is_mtlo, is_mult, is_multu, is_mul, acc_add, acc_sub;
  logic mcmd, valid, idle, accept, sgn_op, neg;
  logic [31:0] mag_a, mag_b, mplier;
  logic [63:0] mcand, prod, p_s, acc;
  logic [4:0] cnt;
  assign alu      = ALUOp & ~MULOp;
  assign mulc     = MULOp & ~ALUOp;
  assign is_mfhi  = alu & (Func == 6'h10);
  assign is_mthi  = alu & (Func == 6'h11);
  assign is_mflo  = alu & (Func == 6'h12);
  assign is_mtlo  = alu & (Func == 6'h13);
  assign is_mult  = alu & (Func == 6'h18);
  assign is_multu = alu & (Func == 6'h19);
  assign is_mul   = mulc & (Func == 6'h02);
`ifdef MUL_ACC_EN
  assign acc_add  = mulc & (Func == 6'h00 | Func == 6'h01);
  assign acc_sub  = mulc & (Func == 6'h04 | Func == 6'h05);
`else
  assign acc_add  = 1'b0;
  assign acc_sub  = 1'b0;
`endif
  assign mcmd   = is_mult | is_multu | is_mul | acc_add | acc_sub;
  assign valid  = mcmd | is_mfhi | is_mthi | is_mflo | is_mtlo;
  assign idle   = (state == IDLE);
  assign accept = idle & mcmd;
  assign Busy   = ~idle;
  assign Stall  = valid & ~idle;
  assign sgn_op = is_mult | is_mul | ((acc_add | acc_sub) & ~Func[0]);
  assign mag_a  = (sgn_op & A[31]) ? -A : A;
  assign mag_b  = (sgn_op & B[31]) ? -B : B;
  assign op_nxt = is_mul ? OP_MUL : acc_add ? OP_MADD : acc_sub ? OP_MSUB : OP_MULT;
  assign p_s    = neg ? -prod : prod;
`ifdef MUL_ACC_EN
  assign acc = (op == OP_MADD) ? {HI, LO} + p_s : (op == OP_MSUB) ? {HI, LO} - p_s : p_s;
`else
  assign acc = p_s;
`endif
  // Reset gates the read port so outputs clear the instant nReset falls.
  assign ResultValid = nReset & (((state == FIN) & (op == OP_MUL)) | (idle & (is_mfhi | is_mflo)));
  assign Result = !nReset ? 32'd0 :
                  ((state == FIN) & (op == OP_MUL)) ? p_s[31:0] :
                  (idle & is_mfhi) ? HI :
                  (idle & is_mflo) ? LO : 32'd0;
  always_comb begin
    state_nxt = IDLE;
    state_nxt = (state == IDLE) ? (accept ? MULT : IDLE) :
                (state == MULT) ? ((cnt == 5'd31) ? FIN : MULT) : IDLE;
  end
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      op     <= OP_MULT;
      HI     <= '0;
      LO     <= '0;
    end else begin
      if (accept) begin
        mcand  <= {32'd0, mag_a};
        mplier <= mag_b;
        prod   <= '0;
        cnt    <= '0;
        neg    <= sgn_op & (A[31] ^ B[31]);
        op     <= op_nxt;
      end else if (state == MULT) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
      end
      if (idle & is_mthi) HI <= A;
      if (idle & is_mtlo) LO <= A;
      if ((state == FIN) & (op != OP_MUL)) {HI, LO} <= acc;
    end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and randomized checks of mul_unit against a 64-bit arithmetic reference model.
module tb_mul_unit;
  logic Clk = 0, nReset = 1, ALUOp = 0, MULOp = 0;
  logic [5:0] Func = 6'h3f;
  logic [31:0] A = 0, B = 0;
  logic Busy, Stall, ResultValid;
  logic [31:0] Result, HI, LO;
  int checks = 0, errors = 0;
  logic [63:0] m_hilo = 0;

  mul_unit dut (.Clk(Clk), .nReset(nReset), .ALUOp(ALUOp), .MULOp(MULOp), .Func(Func), .A(A), .B(B),
                .Busy(Busy), .Stall(Stall), .Result(Result), .ResultValid(ResultValid), .HI(HI), .LO(LO));

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    ALUOp = 0; MULOp = 0; Func = 6'h3f; A = 0; B = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic rd(input bit hi);
    ALUOp = 1; MULOp = 0; Func = hi ? 6'h10 : 6'h12;
    #1;
    chk("rd_valid", 64'(ResultValid), 64'd1);
    chk("rd_data", 64'(Result), hi ? 64'(m_hilo[63:32]) : 64'(m_hilo[31:0]));
    chk("rd_stall", 64'(Stall), 64'd0);
    idle_in();
    tick();
  endtask

  task automatic wr(input bit hi, input logic [31:0] v);
    ALUOp = 1; MULOp = 0; Func = hi ? 6'h11 : 6'h13; A = v;
    tick();
    idle_in();
    if (hi) m_hilo[63:32] = v; else m_hilo[31:0] = v;
    chk("wr_busy", 64'(Busy), 64'd0);
    chk("wr_hilo", {HI, LO}, m_hilo);
  endtask

  task automatic run_mul(input bit mo, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] old;
    logic [31:0] junk;
    bit sg, is_mul;
    int n;
    old = m_hilo;
    junk = $urandom;
    n = 0;
    is_mul = mo && f == 6'h02;
    sg = mo ? (f == 6'h00 || f == 6'h02 || f == 6'h04) : (f == 6'h18);
    p = sg ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) : {32'd0, a} * {32'd0, b};
    ALUOp = !mo; MULOp = mo; Func = f; A = a; B = b;
    #1;
    chk("pre_stall", 64'(Stall), 64'd0);
    chk("pre_busy", 64'(Busy), 64'd0);
    tick();
    idle_in();
    while (Busy && n < 40) begin
      n++;
      if (n == 5) begin
        ALUOp = 1; MULOp = 0; Func = 6'h12;
        #1;
        chk("busy_stall", 64'(Stall), 64'd1);
        chk("busy_rv", 64'(ResultValid), 64'd0);
        idle_in();
      end
      if (n == 10) begin ALUOp = 1; MULOp = 0; Func = 6'h11; A = junk; end
      if (n == 11) idle_in();
      if (n == 33) begin
        chk("fin_rv", 64'(ResultValid), 64'(is_mul));
        chk("fin_res", 64'(Result), is_mul ? 64'(p[31:0]) : 64'd0);
        chk("hilo_hold", {HI, LO}, old);
      end
      tick();
    end
    chk("busy_cycles", 64'(n), 64'd33);
    if (!mo) m_hilo = p;
    else if (f == 6'h00 || f == 6'h01) m_hilo = m_hilo + p;
    else if (f == 6'h04 || f == 6'h05) m_hilo = m_hilo - p;
    chk("hilo", {HI, LO}, m_hilo);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hffff_ffff;
      2: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] kinds[$];
    logic [7:0] bad[4];
    logic [7:0] k;
    kinds = '{{1'b0, 1'b0, 6'h18}, {1'b0, 1'b0, 6'h19}, {1'b0, 1'b1, 6'h02}};
`ifdef MUL_ACC_EN
    kinds.push_back({2'b01, 6'h00}); kinds.push_back({2'b01, 6'h01});
    kinds.push_back({2'b01, 6'h04}); kinds.push_back({2'b01, 6'h05});
`endif
    idle_in();
    #2 nReset = 0;
    ALUOp = 1; Func = 6'h10;
    #1;
    chk("rst_rv", 64'(ResultValid), 64'd0);
    chk("rst_res", 64'(Result), 64'd0);
    tick(); tick();
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    idle_in();
    nReset = 1;
    run_mul(0, 6'h18, 32'hffff_ffff, 32'h0000_0002);
    chk("mult_hi", 64'(HI), 64'hffff_ffff);
    chk("mult_lo", 64'(LO), 64'hffff_fffe);
    run_mul(0, 6'h19, 32'hffff_ffff, 32'hffff_ffff);
    chk("multu_hilo", {HI, LO}, 64'hffff_fffe_0000_0001);
    rd(1); rd(0);
    run_mul(1, 6'h02, 32'd7, 32'hffff_fffa);
    rd(0);
    run_mul(1, 6'h02, 32'h8000_0000, 32'h8000_0000);
    wr(1, 32'd0);
    wr(0, 32'd10);
`ifdef MUL_ACC_EN
    run_mul(1, 6'h00, 32'd3, 32'd4);
    chk("madd_hilo", {HI, LO}, 64'd22);
    run_mul(1, 6'h04, 32'd1, 32'h8000_0000);
    chk("msub_hilo", {HI, LO}, 64'h0000_0000_8000_0016);
`else
    MULOp = 1; Func = 6'h00; A = 3; B = 4;
    #1;
    chk("noacc_stall", 64'(Stall), 64'd0);
    tick(); idle_in(); tick();
    chk("noacc_busy", 64'(Busy), 64'd0);
    chk("noacc_hilo", {HI, LO}, m_hilo);
`endif
    bad = '{{2'b11, 6'h18}, {2'b10, 6'h02}, {2'b01, 6'h10}, {2'b00, 6'h19}};
    foreach (bad[i]) begin
      ALUOp = bad[i][7]; MULOp = bad[i][6]; Func = bad[i][5:0]; A = $urandom; B = $urandom;
      #1;
      chk("nocmd_stall", 64'(Stall), 64'd0);
      chk("nocmd_rv", 64'(ResultValid), 64'd0);
      tick();
      chk("nocmd_busy", 64'(Busy), 64'd0);
      chk("nocmd_hilo", {HI, LO}, m_hilo);
    end
    idle_in();
    for (int i = 0; i < 8; i++) begin
      k = kinds[$urandom_range(0, kinds.size() - 1)];
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 1) == 1, $urandom);
      run_mul(k[6], k[5:0], rnd_op(), rnd_op());
    end
    wr(1, 32'h1234_5678);
    ALUOp = 1; Func = 6'h18; A = $urandom; B = $urandom;
    tick(); idle_in();
    for (int i = 0; i < 10; i++) tick();
    nReset = 0;
    #1;
    m_hilo = 0;
    chk("midrst_hilo", {HI, LO}, 64'd0);
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_rv", 64'(ResultValid), 64'd0);
    tick();
    nReset = 1;
    run_mul(0, 6'h18, 32'd5, 32'd5);
    chk("post_rst_lo", 64'(LO), 64'd25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
